// File: rtl/three_by_three_systolic_array.sv
// 3x3 weight-stationary systolic tile: 2x2 valid cross-correlation of a 4x4 image
// with a 3x3 kernel. It runs once after each reset release.
module three_by_three_systolic_array #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] i00, i01, i02, i03,
  input  logic [DW-1:0] i10, i11, i12, i13,
  input  logic [DW-1:0] i20, i21, i22, i23,
  input  logic [DW-1:0] i30, i31, i32, i33,
  input  logic [DW-1:0] f00, f01, f02,
  input  logic [DW-1:0] f10, f11, f12,
  input  logic [DW-1:0] f20, f21, f22,
  output logic [DW-1:0] o00,
  output logic [DW-1:0] o01,
  output logic [DW-1:0] o10,
  output logic [DW-1:0] o11
);

  localparam int AW = 20;

  logic [DW-1:0]   w_img_in [4][4];
  logic [DW-1:0]   w_ker_in [3][3];
  logic [DW-1:0]   w_feed   [3];
  logic [DW-1:0]   w_x_in   [3][3];
  logic [AW-1:0]   w_ps_in  [3][3];
  logic [2*DW-1:0] w_prod   [3][3];
  logic [AW-1:0]   w_col_sum;
  logic [DW-1:0]   w_result;

  logic [3:0]      r_cnt;
  logic [DW-1:0]   r_img [4][4];
  logic [DW-1:0]   r_w   [3][3];
  logic [DW-1:0]   r_x   [3][3];
  logic [AW-1:0]   r_ps  [3][3];
  logic [DW-1:0]   r_hold;
  logic [DW-1:0]   r_o00, r_o01, r_o10, r_o11;

  assign w_img_in = '{'{i00, i01, i02, i03}, '{i10, i11, i12, i13},
                      '{i20, i21, i22, i23}, '{i30, i31, i32, i33}};
  assign w_ker_in = '{'{f00, f01, f02}, '{f10, f11, f12}, '{f20, f21, f22}};

  // Array row r streams image rows r (pass 0) then r+1 (pass 1), right-to-left,
  // starting at cnt==2+r. Because of that reversal, every column bottom holds its
  // term for the same output at the same cycle.
  always_comb begin
    logic [3:0] s;
    for (int r = 0; r < 3; r++) begin
      w_feed[r] = '0;
      s = r_cnt - 4'(2 + r);
      if (r_cnt >= 4'(2 + r) && s < 4'd8)
        w_feed[r] = r_img[2'(r) + {1'b0, s[2]}][2'd3 - s[1:0]];
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_x_in[r][0]  = w_feed[r];
      w_x_in[r][1]  = r_x[r][0];
      w_x_in[r][2]  = r_x[r][1];
      w_ps_in[0][r] = '0;
    end
    for (int r = 1; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w_ps_in[r][c] = r_ps[r-1][c];
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w_prod[r][c] = (2*DW)'(w_x_in[r][c]) * (2*DW)'(r_w[r][c]);
  end

  assign w_col_sum = r_ps[2][0] + r_ps[2][1] + r_ps[2][2];
  assign w_result  = w_col_sum[DW-1:0];

  // NOTE: the capture and PE arrays are small flop banks, so they are reset like
  // any other register. They are not inferred as RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          r_img[r][c] <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          r_w[r][c]  <= '0;
          r_x[r][c]  <= '0;
          r_ps[r][c] <= '0;
        end
    end else begin
      if (r_cnt != 4'd15) r_cnt <= r_cnt + 4'd1;
      if (r_cnt == 4'd0) begin
        r_img <= w_img_in;
        r_w   <= w_ker_in;
      end
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          r_x[r][c]  <= w_x_in[r][c];
          r_ps[r][c] <= w_ps_in[r][c] + AW'(w_prod[r][c]);
        end
    end
  end

  // The column-1 result of each pass lands one cycle before column 0. It is held
  // so that both outputs of a pass update on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold <= '0;
      r_o00  <= '0;
      r_o01  <= '0;
      r_o10  <= '0;
      r_o11  <= '0;
    end else begin
      if (r_cnt == 4'd7 || r_cnt == 4'd11) r_hold <= w_result;
      if (r_cnt == 4'd8) begin
        r_o00 <= w_result;
        r_o01 <= r_hold;
      end
      if (r_cnt == 4'd12) begin
        r_o10 <= w_result;
        r_o11 <= r_hold;
      end
    end
  end

  assign o00 = r_o00;
  assign o01 = r_o01;
  assign o10 = r_o10;
  assign o11 = r_o11;

endmodule

// File: tb/tb_three_by_three_systolic_array.sv
// Directed bench for three_by_three_systolic_array. Expected results are hand-computed
// convolutions. Inputs are driven and outputs sampled on the falling edge.
module tb_three_by_three_systolic_array;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] img [4][4];
  logic [7:0] ker [3][3];
  logic [7:0] o00, o01, o10, o11;
  int         total = 0;
  int         bad   = 0;

  logic [7:0] nom_img [4][4] = '{'{8'd8, 8'd3, 8'd9, 8'd1}, '{8'd7, 8'd7, 8'd2, 8'd8},
                                 '{8'd5, 8'd6, 8'd3, 8'd1}, '{8'd4, 8'd9, 8'd2, 8'd6}};
  logic [7:0] nom_ker [3][3] = '{'{8'd1, 8'd5, 8'd8}, '{8'd6, 8'd0, 8'd7},
                                 '{8'd3, 8'd1, 8'd2}};

  always #5 clk = ~clk;

  three_by_three_systolic_array #(.DW(8)) dut (
    .clk(clk), .rst(rst),
    .i00(img[0][0]), .i01(img[0][1]), .i02(img[0][2]), .i03(img[0][3]),
    .i10(img[1][0]), .i11(img[1][1]), .i12(img[1][2]), .i13(img[1][3]),
    .i20(img[2][0]), .i21(img[2][1]), .i22(img[2][2]), .i23(img[2][3]),
    .i30(img[3][0]), .i31(img[3][1]), .i32(img[3][2]), .i33(img[3][3]),
    .f00(ker[0][0]), .f01(ker[0][1]), .f02(ker[0][2]),
    .f10(ker[1][0]), .f11(ker[1][1]), .f12(ker[1][2]),
    .f20(ker[2][0]), .f21(ker[2][1]), .f22(ker[2][2]),
    .o00(o00), .o01(o01), .o10(o10), .o11(o11)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [7:0] e00, input logic [7:0] e01,
                        input logic [7:0] e10, input logic [7:0] e11);
    check({tag, ".o00"}, o00, e00);
    check({tag, ".o01"}, o01, e01);
    check({tag, ".o10"}, o10, e10);
    check({tag, ".o11"}, o11, e11);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_all(input logic [7:0] iv, input logic [7:0] kv);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) img[r][c] = iv;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) ker[r][c] = kv;
  endtask

  // Holds reset for three cycles, then releases it on a falling edge. The next
  // rising edge is the capture edge (cnt==0).
  task automatic restart();
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    img = nom_img;
    ker = nom_ker;

    // Outputs must read 0 throughout reset.
    tick(2);
    check4("in_reset", 8'd0, 8'd0, 8'd0, 8'd0);

    // Nominal run. After N rising edges since release, cnt reads N.
    restart();
    tick(8);
    check4("pre_cnt8", 8'd0, 8'd0, 8'd0, 8'd0);
    tick(1);
    check4("cnt9", 8'd178, 8'd177, 8'd0, 8'd0);
    tick(3);
    check4("cnt12_pre", 8'd178, 8'd177, 8'd0, 8'd0);
    tick(1);
    check4("cnt13", 8'd178, 8'd177, 8'd134, 8'd165);
    tick(40);
    check4("stable50", 8'd178, 8'd177, 8'd134, 8'd165);

    // Inputs that change after the capture edge must have no effect.
    restart();
    tick(2);
    set_all(8'd0, 8'd0);
    tick(11);
    check4("late_change", 8'd178, 8'd177, 8'd134, 8'd165);

    // Reset asserted mid-run clears outputs at once. The next run recaptures.
    img = nom_img;
    ker = nom_ker;
    restart();
    tick(10);
    check("mid_pre.o00", o00, 8'd178);
    rst = 1'b0;
    #1;
    check4("mid_async_clear", 8'd0, 8'd0, 8'd0, 8'd0);
    set_all(8'd1, 8'd1);
    restart();
    tick(13);
    check4("mid_rerun_ones", 8'd9, 8'd9, 8'd9, 8'd9);

    // All-max operands: 9*65025 = 585225 = 0x8EE09, so the low byte is 9.
    set_all(8'd255, 8'd255);
    restart();
    tick(13);
    check4("all_max", 8'd9, 8'd9, 8'd9, 8'd9);

    // Identity kernel selects the centre 2x2 of the image.
    img = nom_img;
    set_all(8'd8, 8'd0);
    img = nom_img;
    ker[1][1] = 8'd1;
    restart();
    tick(13);
    check4("identity", 8'd7, 8'd2, 8'd6, 8'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
